// File: rtl/game_pkg.sv
// Shared state encoding, default geometry/speed constants and the return-speed clamp
// used by the ball game controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        MOVE_LEFT,
        HIT_HOLD,
        MOVE_RIGHT,
        MISS,
        GAME_OVER
    } game_state_t;

    localparam int GAME_H_ACT        = 640;
    localparam int GAME_V_ACT        = 480;
    localparam int GAME_BALL_SIZE    = 20;
    localparam int GAME_HIT_ZONE_W   = 80;
    localparam int GAME_SPEED_INIT   = 2;
    localparam int GAME_SPEED_MIN    = 1;
    localparam int GAME_SPEED_MAX    = 12;
    localparam int GAME_VY           = 2;
    localparam int GAME_HOLD_FRAMES  = 8;
    localparam int GAME_SERVE_FRAMES = 60;
    localparam int GAME_LIVES        = 3;

    // Widened to 11 bits so a 10-bit estimate can never wrap during the compare.
    function automatic logic [10:0] clamp_speed(input logic [9:0]  est,
                                                input logic [10:0] lo,
                                                input logic [10:0] hi);
        logic [10:0] e;
        e = {1'b0, est};
        if (e < lo) return lo;
        if (e > hi) return hi;
        return e;
    endfunction

endpackage

// File: rtl/ball_hit_latch.sv
// Captures the first collision of a frame together with its speed estimate; the
// controller consumes it on the following frame_start.
module ball_hit_latch #(
    parameter int SPEED_W = 10
) (
    input  logic               clk_i,
    input  logic               clear_i,
    input  logic               arm_i,
    input  logic               frame_start_i,
    input  logic               collision_i,
    input  logic [SPEED_W-1:0] speed_i,
    output logic               hit_o,
    output logic [SPEED_W-1:0] speed_o
);

    logic               hit_q;
    logic [SPEED_W-1:0] speed_q;
    logic               take;

    assign take = arm_i & collision_i;

    // A pulse on the frame_start cycle opens the new frame's capture rather than
    // being folded into the one just consumed.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            hit_q   <= 1'b0;
            speed_q <= '0;
        end else if (frame_start_i) begin
            hit_q <= take;
            if (take) speed_q <= speed_i;
        end else if (take && !hit_q) begin
            hit_q   <= 1'b1;
            speed_q <= speed_i;
        end
    end

    assign hit_o   = hit_q;
    assign speed_o = speed_q;

endmodule

// File: rtl/ball_game_controller.sv
// Frame-rate game sequencer: moves and bounces the ball, feeds the collision
// detector its hit window, and keeps score, lives and game-over.
module ball_game_controller
    import game_pkg::*;
#(
    parameter int H_ACT        = GAME_H_ACT,
    parameter int V_ACT        = GAME_V_ACT,
    parameter int BALL_SIZE    = GAME_BALL_SIZE,
    parameter int HIT_ZONE_W   = GAME_HIT_ZONE_W,
    parameter int SPEED_INIT   = GAME_SPEED_INIT,
    parameter int SPEED_MIN    = GAME_SPEED_MIN,
    parameter int SPEED_MAX    = GAME_SPEED_MAX,
    parameter int VY           = GAME_VY,
    parameter int HOLD_FRAMES  = GAME_HOLD_FRAMES,
    parameter int SERVE_FRAMES = GAME_SERVE_FRAMES,
    parameter int LIVES        = GAME_LIVES
) (
    input  logic       clk_25MHz,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic [9:0] x_pixel,
    input  logic [9:0] y_pixel,
    input  logic       collision_detected,
    input  logic [9:0] estimated_speed,
    input  logic       start_btn,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_pixel,
    output logic       is_hit_area,
    output logic       is_ball_moving_left,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam logic [9:0] X_MAX = 10'(H_ACT - BALL_SIZE);
    localparam logic [9:0] Y_MAX = 10'(V_ACT - BALL_SIZE);
    localparam logic [9:0] X_CTR = 10'((H_ACT - BALL_SIZE) / 2);
    localparam logic [9:0] Y_CTR = 10'((V_ACT - BALL_SIZE) / 2);

    game_state_t state_q, state_d;
    logic [9:0]  ball_x_q, ball_x_d;
    logic [9:0]  ball_y_q, ball_y_d;
    logic [9:0]  speed_q, speed_d;
    logic        dir_left_q, dir_left_d;
    logic        dir_down_q, dir_down_d;
    logic [7:0]  score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  serve_q, serve_d;
    logic        pend_q, pend_d;

    logic        hit_valid;
    logic [9:0]  hit_speed;
    logic        hit_arm;
    logic [10:0] ret_speed;
    logic [10:0] right_sum;
    logic [10:0] hit_sum;
    logic [9:0]  y_move;
    logic        dd_move;
    logic        enter_serve;
    logic        in_rows;
    logic        in_cols;

    // On the frame_start cycle the capture belongs to the frame being entered.
    assign hit_arm = frame_start ? (state_d == MOVE_LEFT) : (state_q == MOVE_LEFT);

    ball_hit_latch #(.SPEED_W(10)) u_hit_latch (
        .clk_i         (clk_25MHz),
        .clear_i       (!reset_n),
        .arm_i         (hit_arm),
        .frame_start_i (frame_start),
        .collision_i   (collision_detected),
        .speed_i       (estimated_speed),
        .hit_o         (hit_valid),
        .speed_o       (hit_speed)
    );

    assign ret_speed = clamp_speed(hit_speed, 11'(SPEED_MIN), 11'(SPEED_MAX));
    assign right_sum = {1'b0, ball_x_q} + {1'b0, speed_q};
    assign hit_sum   = {1'b0, ball_x_q} + ret_speed;

    always_comb begin
        y_move  = ball_y_q;
        dd_move = dir_down_q;
        if (dir_down_q) begin
            if ({1'b0, ball_y_q} + 11'(VY) > {1'b0, Y_MAX}) begin
                y_move  = Y_MAX;
                dd_move = 1'b0;
            end else begin
                y_move = ball_y_q + 10'(VY);
            end
        end else if (ball_y_q < 10'(VY)) begin
            y_move  = '0;
            dd_move = 1'b1;
        end else begin
            y_move = ball_y_q - 10'(VY);
        end
    end

    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        speed_d     = speed_q;
        dir_left_d  = dir_left_q;
        dir_down_d  = dir_down_q;
        score_d     = score_q;
        lives_d     = lives_q;
        hold_d      = hold_q;
        serve_d     = serve_q;
        pend_d      = pend_q;
        enter_serve = 1'b0;
        if (frame_start) begin
            pend_d = 1'b0;
            case (state_q)
                IDLE: enter_serve = pend_q | start_btn;
                SERVE: begin
                    if (serve_q >= 8'(SERVE_FRAMES - 1)) state_d = MOVE_LEFT;
                    else                                  serve_d = serve_q + 8'd1;
                end
                MOVE_LEFT: begin
                    ball_y_d   = y_move;
                    dir_down_d = dd_move;
                    if (hit_valid) begin
                        speed_d    = ret_speed[9:0];
                        dir_left_d = 1'b0;
                        score_d    = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        hold_d     = 8'(HOLD_FRAMES);
                        state_d    = HIT_HOLD;
                        // A return that would overshoot the right wall parks on it.
                        ball_x_d   = (hit_sum >= {1'b0, X_MAX}) ? X_MAX : hit_sum[9:0];
                    end else if (ball_x_q <= speed_q) begin
                        ball_x_d = '0;
                        state_d  = MISS;
                    end else begin
                        ball_x_d = ball_x_q - speed_q;
                    end
                end
                HIT_HOLD, MOVE_RIGHT: begin
                    ball_y_d   = y_move;
                    dir_down_d = dd_move;
                    if (right_sum >= {1'b0, X_MAX}) begin
                        ball_x_d   = X_MAX;
                        dir_left_d = 1'b1;
                        state_d    = MOVE_LEFT;
                    end else begin
                        ball_x_d = right_sum[9:0];
                        if (state_q == HIT_HOLD) begin
                            hold_d = hold_q - 8'd1;
                            if (hold_q <= 8'd1) state_d = MOVE_RIGHT;
                        end
                    end
                end
                MISS: begin
                    if (lives_q <= 2'd1) begin
                        lives_d = '0;
                        state_d = GAME_OVER;
                    end else begin
                        lives_d     = lives_q - 2'd1;
                        enter_serve = 1'b1;
                    end
                end
                GAME_OVER: begin
                    if (pend_q | start_btn) begin
                        lives_d     = 2'(LIVES);
                        score_d     = '0;
                        enter_serve = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (enter_serve) begin
                state_d    = SERVE;
                ball_x_d   = X_CTR;
                ball_y_d   = Y_CTR;
                speed_d    = 10'(SPEED_INIT);
                dir_left_d = 1'b1;
                serve_d    = '0;
            end
        end else if ((state_q == IDLE || state_q == GAME_OVER) && start_btn) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ball_x_q   <= X_CTR;
            ball_y_q   <= Y_CTR;
            speed_q    <= 10'(SPEED_INIT);
            dir_left_q <= 1'b1;
            dir_down_q <= 1'b1;
            score_q    <= '0;
            lives_q    <= 2'(LIVES);
            hold_q     <= '0;
            serve_q    <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            speed_q    <= speed_d;
            dir_left_q <= dir_left_d;
            dir_down_q <= dir_down_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            hold_q     <= hold_d;
            serve_q    <= serve_d;
            pend_q     <= pend_d;
        end
    end

    assign in_cols = ({1'b0, x_pixel} >= {1'b0, ball_x_q}) &&
                     ({1'b0, x_pixel} <  {1'b0, ball_x_q} + 11'(BALL_SIZE));
    assign in_rows = ({1'b0, y_pixel} >= {1'b0, ball_y_q}) &&
                     ({1'b0, y_pixel} <  {1'b0, ball_y_q} + 11'(BALL_SIZE));

    assign ball_pixel          = in_cols && in_rows;
    assign is_hit_area         = (state_q == MOVE_LEFT) && (x_pixel < 10'(HIT_ZONE_W)) && in_rows;
    assign is_ball_moving_left = dir_left_q;
    assign ball_x              = ball_x_q;
    assign ball_y              = ball_y_q;
    assign score               = score_q;
    assign lives               = lives_q;
    assign game_over           = (state_q == GAME_OVER);

endmodule
